// File: rtl/uart_alu_interface_if.sv
// Bus between the UART/ALU byte sequencer and its receiver, ALU and transmitter.
// The master modport is the sequencer; the slave modport is the surrounding datapath.
interface uart_alu_interface_if #(
  parameter int unsigned DBIT  = 8,
  parameter int unsigned NB_OP = 6
);
  logic [DBIT-1:0]  rx_data;
  logic             rx_done;
  logic [DBIT-1:0]  alu_result;
  logic             tx_done;
  logic [DBIT-1:0]  dato_a;
  logic [DBIT-1:0]  dato_b;
  logic [NB_OP-1:0] opcode;
  logic [DBIT-1:0]  tx_data;
  logic             tx_start;
  logic             busy;
  logic             timeout;

  modport master (
    input  rx_data, rx_done, alu_result, tx_done,
    output dato_a, dato_b, opcode, tx_data, tx_start, busy, timeout
  );

  modport slave (
    output rx_data, rx_done, alu_result, tx_done,
    input  dato_a, dato_b, opcode, tx_data, tx_start, busy, timeout
  );
endinterface

// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode bytes from the receiver, captures the ALU result
// and launches one transmission; partial frames are dropped after an inter-byte timeout.
module uart_alu_interface #(
  parameter int unsigned DBIT        = 8,
  parameter int unsigned NB_OP       = 6,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input logic                 clk,
  input logic                 rst_n,
  uart_alu_interface_if.master bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  localparam logic [2:0] StWaitA  = 3'd0;
  localparam logic [2:0] StWaitB  = 3'd1;
  localparam logic [2:0] StWaitOp = 3'd2;
  localparam logic [2:0] StCalc   = 3'd3;
  localparam logic [2:0] StSend   = 3'd4;
  localparam logic [2:0] StWaitTx = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [DBIT-1:0]  dato_a_q, dato_a_d;
  logic [DBIT-1:0]  dato_b_q, dato_b_d;
  logic [NB_OP-1:0] opcode_q, opcode_d;
  logic [DBIT-1:0]  tx_data_q, tx_data_d;
  logic             timeout_pulse;
  logic [CntW-1:0]  cnt_inc;

  // Saturating increment so the gap counter can never wrap.
  assign cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    dato_a_d      = dato_a_q;
    dato_b_d      = dato_b_q;
    opcode_d      = opcode_q;
    tx_data_d     = tx_data_q;
    timeout_pulse = 1'b0;
    unique case (state_q)
      StWaitA: begin
        if (bus.rx_done) begin
          dato_a_d = bus.rx_data;
          state_d  = StWaitB;
        end
      end
      StWaitB: begin
        if (bus.rx_done) begin
          dato_b_d = bus.rx_data;
          state_d  = StWaitOp;
        end else if (cnt_q == CntLast) begin
          timeout_pulse = 1'b1;
          state_d       = StWaitA;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWaitOp: begin
        if (bus.rx_done) begin
          opcode_d = bus.rx_data[NB_OP-1:0];
          state_d  = StCalc;
        end else if (cnt_q == CntLast) begin
          timeout_pulse = 1'b1;
          state_d       = StWaitA;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StCalc: begin
        tx_data_d = bus.alu_result;
        state_d   = StSend;
      end
      StSend: begin
        state_d = StWaitTx;
      end
      StWaitTx: begin
        if (bus.tx_done) begin
          state_d = StWaitA;
        end
      end
      default: begin
        state_d = StWaitA;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StWaitA;
      cnt_q     <= '0;
      dato_a_q  <= '0;
      dato_b_q  <= '0;
      opcode_q  <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dato_a_q  <= dato_a_d;
      dato_b_q  <= dato_b_d;
      opcode_q  <= opcode_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign bus.dato_a   = dato_a_q;
  assign bus.dato_b   = dato_b_q;
  assign bus.opcode   = opcode_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = (state_q == StSend);
  assign bus.busy     = (state_q == StCalc) || (state_q == StSend) || (state_q == StWaitTx);
  // Combinational so the pulse lands in the same cycle the counter hits its last value.
  assign bus.timeout  = timeout_pulse;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed and randomized frames against a byte-level model of the sequencer and a toy ALU.
module tb_uart_alu_interface;
  localparam int unsigned DBIT  = 8;
  localparam int unsigned NB_OP = 6;
  localparam int unsigned TO    = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_alu_interface_if #(.DBIT(DBIT), .NB_OP(NB_OP)) bus ();

  uart_alu_interface #(
    .DBIT(DBIT),
    .NB_OP(NB_OP),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  assign bus.alu_result = alu_fn(bus.dato_a, bus.dato_b, bus.opcode);

  int total = 0;
  int bad = 0;
  int starts = 0;
  int touts = 0;
  logic [7:0] exp_a = '0, exp_b = '0, exp_tx = '0;
  logic [5:0] exp_op = '0;

  always @(posedge clk) begin
    if (bus.tx_start) starts <= starts + 1;
    if (bus.timeout) touts <= touts + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dato_a"}, 32'(bus.dato_a), 0);
    check({tag, "_dato_b"}, 32'(bus.dato_b), 0);
    check({tag, "_opcode"}, 32'(bus.opcode), 0);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 0);
    check({tag, "_tx_start"}, 32'(bus.tx_start), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_timeout"}, 32'(bus.timeout), 0);
  endtask

  // Called at a falling edge; holds rx_done for one rising edge.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    bus.rx_data = 8'($urandom);
  endtask

  // Sends the opcode and walks the result through CALC, SEND and WAIT_TX.
  task automatic finish_frame(input logic [7:0] opb, input int txd, input bit inj);
    int s0;
    int t0;
    s0 = starts;
    t0 = touts;
    send_byte(opb);
    exp_op = opb[5:0];
    exp_tx = alu_fn(exp_a, exp_b, exp_op);
    check("calc_opcode", 32'(bus.opcode), 32'(exp_op));
    check("calc_busy", 32'(bus.busy), 1);
    check("calc_tx_start", 32'(bus.tx_start), 0);
    @(negedge clk);
    check("send_tx_start", 32'(bus.tx_start), 1);
    check("send_tx_data", 32'(bus.tx_data), 32'(exp_tx));
    @(negedge clk);
    check("waittx_tx_start", 32'(bus.tx_start), 0);
    check("waittx_busy", 32'(bus.busy), 1);
    if (inj) begin
      send_byte(8'h7F);
      check("drop_dato_a", 32'(bus.dato_a), 32'(exp_a));
      check("drop_dato_b", 32'(bus.dato_b), 32'(exp_b));
      check("drop_opcode", 32'(bus.opcode), 32'(exp_op));
      check("drop_busy", 32'(bus.busy), 1);
    end
    repeat (txd - 1) @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    check("done_busy", 32'(bus.busy), 0);
    check("done_tx_data", 32'(bus.tx_data), 32'(exp_tx));
    check("done_one_start", 32'(starts), 32'(s0 + 1));
    check("done_no_timeout", 32'(touts), 32'(t0));
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                       input int gap, input int txd, input bit inj);
    send_byte(a);
    exp_a = a;
    check("a_dato_a", 32'(bus.dato_a), 32'(exp_a));
    check("a_busy", 32'(bus.busy), 0);
    repeat (gap) @(negedge clk);
    send_byte(b);
    exp_b = b;
    check("b_dato_b", 32'(bus.dato_b), 32'(exp_b));
    check("b_dato_a", 32'(bus.dato_a), 32'(exp_a));
    repeat (gap) @(negedge clk);
    finish_frame(opb, txd, inj);
  endtask

  initial begin
    int s0;
    int t0;
    logic [7:0] ops [6];
    ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24;
    ops[3] = 8'h25; ops[4] = 8'h26; ops[5] = 8'hE0;
    bus.rx_data = '0;
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal frame.
    frame(8'h05, 8'h03, 8'h20, 0, 3, 1'b0);
    check("normal_result", 32'(bus.tx_data), 32'h08);

    // Byte arriving while busy is dropped.
    frame(8'h09, 8'h04, 8'h22, 1, 5, 1'b1);
    frame(8'h01, 8'h01, 8'h20, 0, 2, 1'b0);
    check("after_busy_result", 32'(bus.tx_data), 32'h02);

    // Timeout: one byte then silence.
    t0 = touts;
    send_byte(8'h11);
    exp_a = 8'h11;
    repeat (98) @(negedge clk);
    check("to_before", 32'(bus.timeout), 0);
    @(negedge clk);
    check("to_pulse", 32'(bus.timeout), 1);
    check("to_dato_a", 32'(bus.dato_a), 32'h11);
    check("to_dato_b", 32'(bus.dato_b), 32'(exp_b));
    check("to_opcode", 32'(bus.opcode), 32'(exp_op));
    @(negedge clk);
    check("to_after", 32'(bus.timeout), 0);
    check("to_count", 32'(touts), 32'(t0 + 1));
    frame(8'h02, 8'h04, 8'h20, 0, 4, 1'b0);
    check("to_next_result", 32'(bus.tx_data), 32'h06);

    // Boundary: second byte lands in the last counter cycle.
    t0 = touts;
    send_byte(8'h33);
    exp_a = 8'h33;
    repeat (99) @(negedge clk);
    bus.rx_data = 8'h44;
    bus.rx_done = 1'b1;
    #1;
    check("edge_no_timeout", 32'(bus.timeout), 0);
    @(negedge clk);
    bus.rx_done = 1'b0;
    exp_b = 8'h44;
    check("edge_dato_b", 32'(bus.dato_b), 32'h44);
    finish_frame(8'h20, 3, 1'b0);
    check("edge_result", 32'(bus.tx_data), 32'h77);
    check("edge_touts", 32'(touts), 32'(t0));

    // Asynchronous reset in SEND.
    s0 = starts;
    send_byte(8'h21);
    send_byte(8'h12);
    send_byte(8'h20);
    @(negedge clk);
    check("rst_send_start", 32'(bus.tx_start), 1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("rst_send");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_send_no_start", 32'(starts), 32'(s0));
    check("rst_send_idle", 32'(bus.busy), 0);

    // Asynchronous reset in WAIT_TX.
    send_byte(8'h31);
    send_byte(8'h13);
    send_byte(8'h26);
    repeat (3) @(negedge clk);
    s0 = starts;
    #2 rst_n = 1'b0;
    #1;
    check_zero("rst_waittx");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_waittx_no_start", 32'(starts), 32'(s0));
    exp_a = '0;
    exp_b = '0;
    exp_op = '0;
    frame(8'h0A, 8'h05, 8'h20, 0, 3, 1'b0);
    check("rst_next_result", 32'(bus.tx_data), 32'h0F);

    // Back-to-back frames, tx_done 10 cycles after tx_start.
    s0 = starts;
    frame(8'hF0, 8'h20, 8'h20, 0, 10, 1'b0);
    check("b2b_first", 32'(bus.tx_data), 32'h10);
    frame(8'h5A, 8'h0F, 8'h24, 0, 10, 1'b0);
    check("b2b_second", 32'(bus.tx_data), 32'h0A);
    check("b2b_starts", 32'(starts), 32'(s0 + 2));

    // Randomized frames.
    for (int i = 0; i < 16; i++) begin
      frame(8'($urandom), 8'($urandom), ops[$urandom_range(0, 5)] | 8'($urandom_range(0, 3) << 6),
            $urandom_range(0, 6), $urandom_range(1, 12), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_alu_interface.md
# uart_alu_interface

Byte-sequencing controller between the UART receiver and transmitter in the UART/ALU datapath. It collects three consecutive received bytes: operand A, operand B, then the opcode. It drives them to the combinational ALU, captures the ALU result and launches a single transmission of it. It also enforces an inter-byte timeout, so a partial frame cannot leave the sequencer out of step with the host.

## Interface
- DBIT, 8, data/operand width in bits; must match the receiver and transmitter word width
- NB_OP, 6, opcode width in bits; NB_OP ≤ DBIT
- TIMEOUT_CYC, 1_000_000, clock cycles allowed between accepted bytes of one frame; must be ≥ 2

- i_clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_rx_data  in  DBIT  received byte from the receiver; valid when i_rx_done is high
- i_rx_done  in  1  one-cycle receive-complete tick
- i_alu_result  in  DBIT  combinational ALU output, a function of o_dato_a, o_dato_b and o_opcode
- i_tx_done  in  1  one-cycle transmit-complete tick from the transmitter
- o_dato_a  out  DBIT  registered operand A
- o_dato_b  out  DBIT  registered operand B
- o_opcode  out  NB_OP  registered opcode, i_rx_data[NB_OP-1:0]
- o_tx_data  out  DBIT  registered byte to transmit
- o_tx_start  out  1  one-cycle transmit request
- o_busy  out  1  high while a result is being computed or sent
- o_timeout  out  1  one-cycle pulse when a partial frame is discarded

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, CALC, SEND, WAIT_TX. The reset state is WAIT_A.
- WAIT_A: when i_rx_done is high, latch i_rx_data into o_dato_a and go to WAIT_B.
- WAIT_B: when i_rx_done is high, latch i_rx_data into o_dato_b and go to WAIT_OP.
- WAIT_OP: when i_rx_done is high, latch i_rx_data[NB_OP-1:0] into o_opcode and go to CALC.
- CALC: stays exactly one cycle. Capture i_alu_result into o_tx_data, then go to SEND.
- SEND: stays exactly one cycle. o_tx_start = 1, then go to WAIT_TX.
- WAIT_TX: when i_tx_done is high, go to WAIT_A.
- o_busy = 1 in CALC, SEND and WAIT_TX; o_busy = 0 otherwise.
- o_tx_start is a Moore output: high only in SEND.
- Gap counter:
  - Clears on every accepted byte, and whenever the state is WAIT_A, CALC, SEND or WAIT_TX.
  - Increments by 1 per cycle in WAIT_B and WAIT_OP.
  - Width is $clog2(TIMEOUT_CYC). It saturates and never wraps.
- Timeout: when the counter equals TIMEOUT_CYC-1 in WAIT_B or WAIT_OP and i_rx_done is low:
  - go to WAIT_A;
  - pulse o_timeout for one cycle;
  - leave o_dato_a, o_dato_b and o_opcode unchanged.
- i_rx_done and the timeout condition in the same cycle: the byte is accepted and no timeout occurs.
- i_rx_done while in CALC, SEND or WAIT_TX: the byte is dropped and no register changes.
- i_tx_done outside WAIT_TX is ignored.
- Operand and opcode registers hold their values until overwritten, so the ALU inputs stay stable throughout CALC.

## Timing
- Reset (i_reset = 0) acts immediately, with no clock needed. State returns to WAIT_A, the counter clears, and every output is 0: o_dato_a, o_dato_b, o_opcode, o_tx_data, o_tx_start, o_busy, o_timeout.
- Reset mid-frame or mid-transmit: the frame is lost and no o_tx_start follows release of reset.
- Latency, with the opcode's i_rx_done high in cycle n:
  - o_opcode is updated and the state is CALC in cycle n+1;
  - o_tx_data is valid and o_tx_start is high in cycle n+2;
  - o_busy rises in cycle n+1.
- o_tx_start lasts exactly 1 cycle per frame. o_tx_data is stable from cycle n+2 until the next CALC.
- After i_tx_done in cycle m, the state is WAIT_A in m+1. A byte arriving in cycle m+1 is accepted as the next A.
- Timeout: with the last accepted byte in cycle k, o_timeout pulses in cycle k+TIMEOUT_CYC.

## Test plan
Bench settings: TIMEOUT_CYC = 100; the ALU model returns A + B when opcode = 6'h20.

- Normal frame: rx bytes 0x05, 0x03, 0x20 → o_dato_a = 0x05, o_dato_b = 0x03, o_opcode = 0x20, o_tx_data = 0x08, exactly one o_tx_start two cycles after the third i_rx_done.
- Byte during busy: send 0x7F while in WAIT_TX → operands unchanged and no extra o_tx_start. After i_tx_done, frame 0x01, 0x01, 0x20 → o_tx_data = 0x02.
- Timeout: byte 0x11, then idle 100 cycles → o_timeout pulses in cycle k+100 and the state is WAIT_A. Then 0x02, 0x04, 0x20 → o_tx_data = 0x06.
- Boundary: the second byte arrives exactly in the cycle the counter reaches 99 → byte accepted, no o_timeout, frame completes.
- Async reset asserted in SEND/WAIT_TX → all outputs 0 immediately. No o_tx_start after release. The next frame 0x0A, 0x05, 0x20 → o_tx_data = 0x0F.
- Back-to-back frames: two frames sent with i_tx_done returned 10 cycles after o_tx_start → two o_tx_start pulses with the correct results.
